// File: rtl/display_pkg.sv
// Shared constants for the display register block: register addresses,
// CTRL bit positions and default widths.
package display_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_VAL_W  = 8;
  localparam int FRAME_W    = 16;

  // Register map as seen from the bus.
  typedef enum logic [2:0] {
    ADDR_VALUE = 3'd0,
    ADDR_P1    = 3'd1,
    ADDR_P2    = 3'd2,
    ADDR_P3    = 3'd3,
    ADDR_P4    = 3'd4,
    ADDR_CTRL  = 3'd5,
    ADDR_FRAME = 3'd6,
    ADDR_RSVD  = 3'd7
  } reg_addr_e;

  // Bit positions inside the CTRL register.
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_AUTO   = 1;

endpackage

// File: rtl/display_regs_if.sv
// Simple strobe/ack register bus between the CPU side and display_regs.
interface display_regs_if #(
  parameter int DATA_W = display_pkg::DEF_DATA_W
);
  logic              we;
  logic              re;
  logic [2:0]        addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output we, re, addr, wdata, input rdata, ack);
  modport slave  (input we, re, addr, wdata, output rdata, ack);
endinterface

// File: rtl/vsync_edge.sv
// Polarity-aware leading-edge detector for a same-domain vsync. The raw
// vsync level is registered once; the edge pulse is combinational on the
// current input so it is visible in the cycle vsync arrives.
module vsync_edge #(
  parameter bit ACT_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync_i,
  output logic lead_o
);

  logic vs_q;

  // History flop holding last cycle's raw vsync level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vs_q <= 1'b0;
    else      vs_q <= vsync_i;
  end

  // Leading edge: previous level inactive, current level active.
  assign lead_o = ACT_LOW ? (vs_q & ~vsync_i) : (~vs_q & vsync_i);

endmodule

// File: rtl/display_regs.sv
// Shadow/active register block feeding the VGA top. Software writes the
// shadow set; a commit request copies it into the active set on the next
// vsync leading edge so the screen never changes mid-frame.
module display_regs
  import display_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int VAL_W         = DEF_VAL_W,
  parameter bit VSYNC_ACT_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  display_regs_if.slave      bus,
  input  logic               vsync,
  output logic [VAL_W-1:0]   value,
  output logic [DATA_W-1:0]  p1,
  output logic [DATA_W-1:0]  p2,
  output logic [DATA_W-1:0]  p3,
  output logic [DATA_W-1:0]  p4,
  output logic               commit_pulse
);

  logic [VAL_W-1:0]       sh_val_q, act_val_q;
  logic [3:0][DATA_W-1:0] sh_p_q, act_p_q;
  logic                   pending_q, pending_d;
  logic                   auto_q, auto_d;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic [DATA_W-1:0]      rdata_q, rd_mux;
  logic                   ack_q, commit_q;
  logic                   lead_edge, do_commit, wr_ctrl;

  vsync_edge #(.ACT_LOW(VSYNC_ACT_LOW)) u_vsync_edge (
    .clk     (clk),
    .rst     (rst),
    .vsync_i (vsync),
    .lead_o  (lead_edge)
  );

  assign do_commit = lead_edge & (pending_q | auto_q);
  assign wr_ctrl   = bus.we && (bus.addr == ADDR_CTRL);
  assign frame_d   = frame_q + FRAME_W'(lead_edge);

  // Next pending/auto: a CTRL commit write wins over the clear from a
  // commit in the same cycle, so it is carried to the following frame.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    pending_d = pending_q;
    auto_d    = auto_q;
    if (do_commit) pending_d = 1'b0;
    if (wr_ctrl) begin
      if (bus.wdata[CTRL_COMMIT]) pending_d = 1'b1;
      auto_d = bus.wdata[CTRL_AUTO];
    end
  end

  // Read mux over pre-write register values.
  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      ADDR_VALUE: rd_mux = DATA_W'(sh_val_q);
      ADDR_P1:    rd_mux = sh_p_q[0];
      ADDR_P2:    rd_mux = sh_p_q[1];
      ADDR_P3:    rd_mux = sh_p_q[2];
      ADDR_P4:    rd_mux = sh_p_q[3];
      ADDR_CTRL: begin
        rd_mux[CTRL_AUTO]   = auto_q;
        rd_mux[CTRL_COMMIT] = pending_q;
      end
      ADDR_FRAME: rd_mux = DATA_W'(frame_q);
      default:    rd_mux = '0;
    endcase
  end

  // Shadow register writes from the bus.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the register file is small flops, so it is reset along with
    // everything else; the screen shows zeros until the first commit.
    if (!rst) begin
      sh_val_q <= '0;
      sh_p_q   <= '0;
    end else if (bus.we) begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      case (bus.addr)
        ADDR_VALUE: sh_val_q  <= bus.wdata[VAL_W-1:0];
        ADDR_P1:    sh_p_q[0] <= bus.wdata;
        ADDR_P2:    sh_p_q[1] <= bus.wdata;
        ADDR_P3:    sh_p_q[2] <= bus.wdata;
        ADDR_P4:    sh_p_q[3] <= bus.wdata;
        default:    ;
      endcase
    end
  end

  // Active set: copy of the shadow taken at a committing leading edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_val_q <= '0;
      act_p_q   <= '0;
      commit_q  <= 1'b0;
    end else begin
      commit_q <= do_commit;
      if (do_commit) begin
        act_val_q <= sh_val_q;
        act_p_q   <= sh_p_q;
      end
    end
  end

  // Control state and free-running frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= 1'b0;
      auto_q    <= 1'b0;
      frame_q   <= '0;
    end else begin
      pending_q <= pending_d;
      auto_q    <= auto_d;
      frame_q   <= frame_d;
    end
  end

  // Bus response: one ack per strobed cycle, rdata only moves on a read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= bus.we | bus.re;
      if (bus.re) rdata_q <= rd_mux;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ack      = ack_q;
  assign value        = act_val_q;
  assign p1           = act_p_q[0];
  assign p2           = act_p_q[1];
  assign p3           = act_p_q[2];
  assign p4           = act_p_q[3];
  assign commit_pulse = commit_q;

endmodule

// File: tb/tb_display_regs.sv
// Self-checking bench for display_regs: directed scenarios plus a random
// run compared against a behavioural model of the register block.
module tb_display_regs;
  import display_pkg::*;

  localparam int DW = 16;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b1;
  logic [VW-1:0] value;
  logic [DW-1:0] p1, p2, p3, p4;
  logic          commit_pulse;

  display_regs_if #(.DATA_W(DW)) bus ();

  display_regs #(.DATA_W(DW), .VAL_W(VW), .VSYNC_ACT_LOW(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .vsync        (vsync),
    .value        (value),
    .p1           (p1),
    .p2           (p2),
    .p3           (p3),
    .p4           (p4),
    .commit_pulse (commit_pulse)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  logic [VW-1:0] m_sh_val, m_act_val;
  logic [DW-1:0] m_sh_p [4];
  logic [DW-1:0] m_act_p [4];
  bit            m_pend, m_auto, m_ack, m_commit, m_vs_prev;
  logic [15:0]   m_frame;
  logic [DW-1:0] m_rdata;

  function automatic logic [DW-1:0] m_read(input logic [2:0] a);
    case (a)
      ADDR_VALUE: return DW'(m_sh_val);
      ADDR_P1:    return m_sh_p[0];
      ADDR_P2:    return m_sh_p[1];
      ADDR_P3:    return m_sh_p[2];
      ADDR_P4:    return m_sh_p[3];
      ADDR_CTRL:  return DW'({m_auto, m_pend});
      ADDR_FRAME: return DW'(m_frame);
      default:    return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_sh_val = '0; m_act_val = '0;
    for (int i = 0; i < 4; i++) begin m_sh_p[i] = '0; m_act_p[i] = '0; end
    m_pend = 0; m_auto = 0; m_ack = 0; m_commit = 0; m_vs_prev = 0;
    m_frame = '0; m_rdata = '0;
  endtask

  // One clock of the model, using the values present before the edge.
  task automatic model_update(input bit we, input bit re, input logic [2:0] a,
                              input logic [DW-1:0] wd, input bit vs);
    bit lead, cm;
    lead = (vs == 1'b0) && (m_vs_prev == 1'b1);
    m_vs_prev = vs;
    cm = lead && (m_pend || m_auto);
    m_ack = we || re;
    if (re) m_rdata = m_read(a);
    m_commit = cm;
    if (cm) begin
      m_act_val = m_sh_val;
      for (int i = 0; i < 4; i++) m_act_p[i] = m_sh_p[i];
      m_pend = 0;
    end
    if (lead) m_frame = m_frame + 16'd1;
    if (we) begin
      case (a)
        ADDR_VALUE: m_sh_val  = wd[VW-1:0];
        ADDR_P1:    m_sh_p[0] = wd;
        ADDR_P2:    m_sh_p[1] = wd;
        ADDR_P3:    m_sh_p[2] = wd;
        ADDR_P4:    m_sh_p[3] = wd;
        ADDR_CTRL: begin
          if (wd[0]) m_pend = 1;
          m_auto = wd[1];
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit we, input bit re, input logic [2:0] a,
                      input logic [DW-1:0] wd, input bit vs);
    bus.we = we; bus.re = re; bus.addr = a; bus.wdata = wd; vsync = vs;
    @(posedge clk);
    if (rst) model_update(we, re, a, wd, vs);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [DW-1:0] d, input bit vs = 1'b1);
    step(1'b1, 1'b0, a, d, vs);
  endtask

  task automatic rd(input logic [2:0] a, input bit vs = 1'b1);
    step(1'b0, 1'b1, a, '0, vs);
  endtask

  task automatic idle(input bit vs = 1'b1);
    step(1'b0, 1'b0, 3'd0, '0, vs);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      idle(1'b0); idle(1'b0); idle(1'b1); idle(1'b1);
    end
  endtask

  task automatic test_reset();
    bus.we = 0; bus.re = 0; bus.addr = '0; bus.wdata = '0; vsync = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({value, p1, p2, p3, p4, commit_pulse, bus.ack, bus.rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0",
               {value, p1, p2, p3, p4, commit_pulse, bus.ack, bus.rdata});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      checks++;
      if (bus.ack !== 1'b1 || bus.rdata !== 16'h0000) begin
        failures++;
        $display("FAIL reset_read addr=%0d ack=%b rdata=%h required ack=1 rdata=0000",
                 a, bus.ack, bus.rdata);
      end
    end
    idle();
    checks++;
    if (bus.ack !== 1'b0) begin
      failures++;
      $display("FAIL ack_single got=%b required=0", bus.ack);
    end
  endtask

  task automatic test_no_commit();
    wr(ADDR_P1, 16'h1234);
    wr(ADDR_VALUE, 16'h00AB);
    frames(3);
    checks++;
    if (p1 !== 16'h0000 || value !== 8'h00) begin
      failures++;
      $display("FAIL no_commit p1=%h value=%h required 0000/00", p1, value);
    end
    rd(ADDR_FRAME);
    checks++;
    if (bus.rdata !== 16'd3) begin
      failures++;
      $display("FAIL frame_count got=%h required=0003", bus.rdata);
    end
  endtask

  task automatic test_commit();
    wr(ADDR_P2, 16'hBEEF);
    wr(ADDR_CTRL, 16'h0001);
    idle(1'b1);
    idle(1'b0);
    checks++;
    if (p2 !== 16'hBEEF || commit_pulse !== 1'b1 || p1 !== 16'h1234 || value !== 8'hAB) begin
      failures++;
      $display("FAIL commit p2=%h p1=%h value=%h pulse=%b required BEEF/1234/AB/1",
               p2, p1, value, commit_pulse);
    end
    idle(1'b0);
    checks++;
    if (commit_pulse !== 1'b0) begin
      failures++;
      $display("FAIL commit_pulse_width got=%b required=0", commit_pulse);
    end
    idle(1'b1);
    rd(ADDR_CTRL);
    checks++;
    if (bus.rdata !== 16'h0000) begin
      failures++;
      $display("FAIL ctrl_after_commit got=%h required=0000", bus.rdata);
    end
  endtask

  task automatic test_ctrl_race();
    wr(ADDR_P4, 16'h5A5A);
    wr(ADDR_CTRL, 16'h0001, 1'b0);
    checks++;
    if (commit_pulse !== 1'b0 || p4 !== 16'h0000) begin
      failures++;
      $display("FAIL ctrl_race_edge p4=%h pulse=%b required 0000/0", p4, commit_pulse);
    end
    idle(1'b0);
    idle(1'b1);
    rd(ADDR_CTRL);
    checks++;
    if (bus.rdata !== 16'h0001) begin
      failures++;
      $display("FAIL ctrl_race_pending got=%h required=0001", bus.rdata);
    end
    idle(1'b0);
    checks++;
    if (p4 !== 16'h5A5A || commit_pulse !== 1'b1) begin
      failures++;
      $display("FAIL ctrl_race_next p4=%h pulse=%b required 5A5A/1", p4, commit_pulse);
    end
    idle(1'b1);
  endtask

  task automatic test_shadow_race();
    wr(ADDR_CTRL, 16'h0002);
    wr(ADDR_P3, 16'h0001);
    wr(ADDR_P3, 16'h0002, 1'b0);
    checks++;
    if (p3 !== 16'h0001 || commit_pulse !== 1'b1) begin
      failures++;
      $display("FAIL shadow_race_first p3=%h pulse=%b required 0001/1", p3, commit_pulse);
    end
    idle(1'b0); idle(1'b1); idle(1'b1);
    idle(1'b0);
    checks++;
    if (p3 !== 16'h0002) begin
      failures++;
      $display("FAIL shadow_race_second got=%h required=0002", p3);
    end
    idle(1'b1);
    wr(ADDR_CTRL, 16'h0000);
    rd(ADDR_CTRL);
    checks++;
    if (bus.rdata !== 16'h0000) begin
      failures++;
      $display("FAIL auto_clear got=%h required=0000", bus.rdata);
    end
  endtask

  task automatic test_random();
    bit vs;
    vs = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) vs = ~vs;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), DW'($urandom), vs);
      checks++;
      if ({value, p1, p2, p3, p4} !== {m_act_val, m_act_p[0], m_act_p[1], m_act_p[2], m_act_p[3]}
          || commit_pulse !== m_commit || bus.ack !== m_ack || bus.rdata !== m_rdata) begin
        failures++;
        $display("FAIL random cyc=%0d got v=%h p=%h_%h_%h_%h c=%b a=%b r=%h required v=%h p=%h_%h_%h_%h c=%b a=%b r=%h",
                 i, value, p1, p2, p3, p4, commit_pulse, bus.ack, bus.rdata,
                 m_act_val, m_act_p[0], m_act_p[1], m_act_p[2], m_act_p[3],
                 m_commit, m_ack, m_rdata);
      end
    end
    idle(1'b1); idle(1'b1);
  endtask

  task automatic test_frame_wrap();
    force dut.frame_q = 16'hFFFF;
    idle(1'b1);
    release dut.frame_q;
    m_frame = 16'hFFFF;
    rd(ADDR_FRAME);
    checks++;
    if (bus.rdata !== 16'hFFFF) begin
      failures++;
      $display("FAIL frame_preload got=%h required=FFFF", bus.rdata);
    end
    frames(1);
    rd(ADDR_FRAME);
    checks++;
    if (bus.rdata !== 16'h0000) begin
      failures++;
      $display("FAIL frame_wrap got=%h required=0000", bus.rdata);
    end
  endtask

  task automatic test_reset_mid();
    wr(ADDR_P1, 16'hCAFE);
    wr(ADDR_CTRL, 16'h0001);
    idle(1'b0);
    idle(1'b1);
    bus.we = 1'b1; bus.re = 1'b1; bus.addr = ADDR_P2; bus.wdata = 16'h7777;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({value, p1, p2, p3, p4, commit_pulse, bus.ack, bus.rdata} !== '0) begin
      failures++;
      $display("FAIL reset_async got=%h required=0",
               {value, p1, p2, p3, p4, commit_pulse, bus.ack, bus.rdata});
    end
    @(posedge clk); #1;
    checks++;
    if (bus.ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack got=%b required=0", bus.ack);
    end
    bus.we = 1'b0; bus.re = 1'b0;
    rst = 1'b1;
    model_reset();
    rd(ADDR_FRAME);
    checks++;
    if (bus.rdata !== 16'h0000) begin
      failures++;
      $display("FAIL reset_frame got=%h required=0000", bus.rdata);
    end
    rd(ADDR_P1);
    checks++;
    if (bus.rdata !== 16'h0000) begin
      failures++;
      $display("FAIL reset_shadow got=%h required=0000", bus.rdata);
    end
  endtask

  initial begin
    test_reset();
    test_no_commit();
    test_commit();
    test_ctrl_race();
    test_shadow_race();
    test_random();
    test_frame_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
